ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the execute stage. It sits directly downstream of the decode stage, fed through the ID/EX register, and computes 32x32 signed/unsigned products and quotient/remainder pairs one bit per cycle. It stalls the pipeline through `stall_req_o` while busy. It returns a 64-bit `{hi, lo}` result to EX for the HI/LO write-back path.

---
 rtl/ex_muldiv_if.sv | 26 ++
 rtl/ex_muldiv.sv | 121 ++++++++++++
 tb/tb_ex_muldiv.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Handshake bundle between EX and the multi-cycle multiply/divide unit.
// The master is the EX stage; the slave is ex_muldiv.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opa_i;
    logic [WIDTH-1:0]     opb_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_zero_o;
    logic                 stall_req_o;

    modport master (
        output start_i, op_i, opa_i, opb_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o, stall_req_o
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o, stall_req_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Bit-serial 32x32 multiply (shift-add) and restoring divide for the EX stage.
// Operands are processed as magnitudes; signs are restored when the result is registered.
//
// state | meaning
// IDLE  | waiting for start_i
// DIV0  | divide by zero, report zero result for one cycle
// RUN   | one bit per cycle, WIDTH cycles
// DONE  | result_o valid, ready_o pulsed
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_DIV0, S_RUN, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     opd_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   fixed;
    logic [2*WIDTH-1:0]   result_q;
    logic [CW-1:0]        cnt_q;
    logic                 neg_q, rem_neg_q, busy_q;

    logic                 start_ok, a_neg, b_neg, last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [WIDTH+1:0]     trial;

    assign start_ok = bus.start_i && !bus.annul_i;
    assign a_neg    = bus.op_i[0] && bus.opa_i[WIDTH-1];
    assign b_neg    = bus.op_i[0] && bus.opb_i[WIDTH-1];
    assign a_mag    = a_neg ? -bus.opa_i : bus.opa_i;
    assign b_mag    = b_neg ? -bus.opb_i : bus.opb_i;
    assign last     = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok)
                        state_d = (bus.op_i[1] && bus.opb_i == '0) ? S_DIV0 : S_RUN;
            S_DIV0: state_d = S_IDLE;
            S_RUN:  if (bus.annul_i) state_d = S_IDLE;
                    else if (last)   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.stall_req_o = (state_q == S_RUN) || (state_q == S_IDLE && start_ok);
        bus.ready_o     = (state_q == S_DONE) || (state_q == S_DIV0 && !bus.annul_i);
        bus.div_zero_o  = (state_q == S_DIV0) && !bus.annul_i;
        bus.result_o    = bus.div_zero_o ? '0 : result_q;
        bus.busy_o      = busy_q;
    end

    // Multiply keeps {hi, multiplier}; divide keeps {rem, quot}. opd_q is multiplicand or divisor.
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        trial = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opd_q};
        acc_d = acc_q;
        if (op_q[1]) begin
            if (!trial[WIDTH+1]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                 acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
            else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
    end

    always_comb begin
        fixed = acc_d;
        if (op_q == 2'b01 && neg_q) fixed = -acc_d;
        if (op_q == 2'b11) begin
            fixed[WIDTH-1:0]       = neg_q     ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
            fixed[2*WIDTH-1:WIDTH] = rem_neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            opd_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: if (start_ok) begin
                    op_q      <= bus.op_i;
                    opd_q     <= bus.op_i[1] ? b_mag : a_mag;
                    acc_q     <= {{WIDTH{1'b0}}, bus.op_i[1] ? a_mag : b_mag};
                    cnt_q     <= '0;
                    neg_q     <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last && !bus.annul_i) result_q <= fixed;
                end
                S_DIV0: if (!bus.annul_i) result_q <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and random checks of ex_muldiv against a plain-arithmetic reference model.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   errs   = 0;
    int   checks = 0;
    logic [63:0] last_res;

    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) bus ();
    ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return ua * ub;
            2'b01: return 64'(sa * sb);
            2'b10: begin
                if (b == 0) return 64'h0;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: begin
                if (b == 0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] exp;
        int lat, exp_lat;
        bit run_ok, dz;
        exp     = ref_op(op, a, b);
        dz      = op[1] && (b == 0);
        exp_lat = dz ? 1 : 33;
        bus.start_i = 1'b1; bus.op_i = op; bus.opa_i = a; bus.opb_i = b;
        #1;
        check({tag, " stall@t"}, 64'(bus.stall_req_o), 64'd1);
        tick();
        bus.start_i = 1'b0;
        bus.opa_i = $urandom; bus.opb_i = $urandom;
        #1;
        lat = 1; run_ok = 1'b1;
        while (!bus.ready_o && lat < 40) begin
            if (!bus.stall_req_o || !bus.busy_o) run_ok = 1'b0;
            tick(); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall/busy while running"}, 64'(run_ok), 64'd1);
        check({tag, " result"}, bus.result_o, exp);
        check({tag, " div_zero"}, 64'(bus.div_zero_o), 64'(dz));
        check({tag, " stall at ready"}, 64'(bus.stall_req_o), 64'd0);
        check({tag, " busy at ready"}, 64'(bus.busy_o), 64'd1);
        tick(); #1;
        check({tag, " ready after"}, 64'(bus.ready_o), 64'd0);
        check({tag, " busy after"}, 64'(bus.busy_o), 64'd0);
        last_res = exp;
    endtask

    initial begin
        int seen;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.start_i = 1'b0; bus.op_i = 2'b00; bus.opa_i = '0; bus.opb_i = '0; bus.annul_i = 1'b0;
        tick(); tick();
        #1;
        check("reset result", bus.result_o, 64'h0);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset div_zero", 64'(bus.div_zero_o), 64'd0);
        check("reset stall", 64'(bus.stall_req_o), 64'd0);
        rst = 1'b0;
        tick();

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
        check("multu max literal", last_res, 64'hFFFFFFFE_00000001);
        run_op(2'b01, 32'hFFFFFFFD, 32'h00000005, "mult -3*5");
        check("mult literal", last_res, 64'hFFFFFFFF_FFFFFFF1);
        run_op(2'b11, 32'hFFFFFFF9, 32'h00000002, "div -7/2");
        check("div literal", last_res, 64'hFFFFFFFF_FFFFFFFD);
        run_op(2'b10, 32'd100, 32'd7, "divu 100/7");
        check("divu literal", last_res, 64'h00000002_0000000E);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "div overflow");
        check("div overflow literal", last_res, 64'h00000000_80000000);
        run_op(2'b10, 32'd5, 32'd0, "divu by zero");
        run_op(2'b11, 32'hFFFFFFF0, 32'd0, "div by zero");

        // Annul a multiply mid-flight; the previous result must survive.
        run_op(2'b00, 32'd9, 32'd9, "multu 9*9");
        bus.start_i = 1'b1; bus.op_i = 2'b00; bus.opa_i = 32'd1234; bus.opb_i = 32'd5678;
        tick();
        bus.start_i = 1'b0;
        repeat (9) tick();
        bus.annul_i = 1'b1;
        tick();
        bus.annul_i = 1'b0;
        #1;
        check("annul busy", 64'(bus.busy_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o) seen++;
            tick(); #1;
        end
        check("annul no ready", 64'(seen), 64'd0);
        check("annul result kept", bus.result_o, 64'd81);

        bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.op_i = 2'b01; bus.opa_i = 32'd3; bus.opb_i = 32'd3;
        #1;
        check("start+annul stall", 64'(bus.stall_req_o), 64'd0);
        tick();
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        #1;
        check("start+annul busy", 64'(bus.busy_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready_o) seen++;
            tick(); #1;
        end
        check("start+annul no ready", 64'(seen), 64'd0);

        // Reset in the middle of a divide.
        bus.start_i = 1'b1; bus.op_i = 2'b11; bus.opa_i = 32'd1000; bus.opb_i = 32'd3;
        tick();
        bus.start_i = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid rst result", bus.result_o, 64'h0);
        check("mid rst busy", 64'(bus.busy_o), 64'd0);
        check("mid rst ready", 64'(bus.ready_o), 64'd0);
        check("mid rst stall", 64'(bus.stall_req_o), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, "multu 6*7");
        check("multu 6*7 literal", last_res, 64'h2A);

        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (n % 3 == 1) rb = rb >> $urandom_range(0, 31);
            if (n % 5 == 2) ra = -ra;
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", n, rop));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
